ui_func_mmio: RTL and testbench

- Memory-mapped front end for the ui_func accelerator, which computes y = a * isqrt(b) (32b x 32b -> 64b).
- Sits between the schoolRISCV data bus and ui_func.
- Latches operands, issues a one-cycle start, and holds a and b stable for the whole run.
- Captures the 64-bit result and exposes status, a cycle counter, a watchdog and an interrupt to software.

---
 rtl/ui_func_mmio.sv | 207 ++++++++++++++++++++
 tb/tb_ui_func_mmio.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ui_func_mmio.sv
// ---------------------------------------------------------------------------
// ui_func_mmio
//
// Memory-mapped front end for the ui_func accelerator (y = a * isqrt(b)).
// Software writes the operands, then writes START. The block issues a
// one-cycle start pulse and keeps the operands stable while ui_func runs.
// It then captures the 64-bit result and raises done. A watchdog aborts
// a run that never signals its final step.
//
// Register map (word index = bus_addr_i[4:2], byte bits [1:0] ignored):
//   0 A       R/W  operand a
//   1 B       R/W  operand b
//   2 CTRL    W    bit0 START, bit1 CLR (done/err/ovr), bit2 IE; reads 0
//   3 STATUS  R    bit0 busy, bit1 done, bit2 err, bit3 ie, bit4 ovr
//   4 RES_LO  R    result [31:0]
//   5 RES_HI  R    result [63:32]
//   6 CYC     R    RUN cycles of the last run, zero-extended
//   7 -       R    reads 0
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   bus_we_i/addr/wdata   write strobe, byte address, write data
//   bus_rdata_o           combinational read data for bus_addr_i
//   func_rst_o            reset to ui_func (rst_i or watchdog abort)
//   func_start_o          one-cycle start pulse to ui_func
//   func_a_o, func_b_o    operands, held stable for the whole run
//   func_y_i              64-bit result from ui_func
//   func_busy_i           ui_func busy (informational, not used)
//   func_end_step_i       ui_func final-iteration flag
//   irq_o                 level interrupt = done & ie
// ---------------------------------------------------------------------------
module ui_func_mmio #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] TIMEOUT = 8'd200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_we_i,
  input  logic [4:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        func_rst_o,
  output logic        func_start_o,
  output logic [31:0] func_a_o,
  output logic [31:0] func_b_o,
  input  logic [63:0] func_y_i,
  input  logic        func_busy_i,
  input  logic        func_end_step_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [2:0] IDX_A      = 3'd0;
  localparam logic [2:0] IDX_B      = 3'd1;
  localparam logic [2:0] IDX_CTRL   = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_RES_LO = 3'd4;
  localparam logic [2:0] IDX_RES_HI = 3'd5;
  localparam logic [2:0] IDX_CYC    = 3'd6;

  state_t           state_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [63:0]      res_q;
  logic [CNT_W-1:0] cyc_q;
  logic             done_q;
  logic             err_q;
  logic             ovr_q;
  logic             ie_q;
  logic             start_q;
  logic             abort_q;

  // Byte-offset bits and the ui_func busy flag are intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus_addr_i[1:0], func_busy_i};

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic [2:0]       widx;
  logic             busy;
  logic             wr_a;
  logic             wr_b;
  logic             wr_ctrl;
  logic             start_req;
  logic             clr_req;
  logic             ovr_hit;
  logic [CNT_W-1:0] cyc_inc;
  logic             timeout_hit;

  assign widx      = bus_addr_i[4:2];
  assign busy      = (state_q != IDLE);
  assign wr_a      = bus_we_i && (widx == IDX_A);
  assign wr_b      = bus_we_i && (widx == IDX_B);
  assign wr_ctrl   = bus_we_i && (widx == IDX_CTRL);
  assign start_req = wr_ctrl && bus_wdata_i[0];
  assign clr_req   = wr_ctrl && bus_wdata_i[1];

  // Touching the operands or relaunching mid-run would corrupt the run,
  // so such writes are dropped and flagged instead.
  assign ovr_hit = busy && (wr_a || wr_b || start_req);

  // Saturating increment: the counter sticks at all-ones rather than wrapping.
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  // The watchdog fires when this RUN cycle would bring the count to
  // TIMEOUT without end_step. An end_step in that same cycle still wins.
  assign timeout_hit = (state_q == RUN) && !func_end_step_i && (cyc_inc >= TIMEOUT);

  // -------------------------------------------------------------------------
  // Registers and FSM
  // -------------------------------------------------------------------------
  // NOTE: every sequential assignment uses <= so that all registers update
  // from the values they held before the edge, whatever the statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;

      if (wr_a && !busy) a_q <= bus_wdata_i;
      if (wr_b && !busy) b_q <= bus_wdata_i;
      if (wr_ctrl)       ie_q <= bus_wdata_i[2];

      // A hardware set takes priority over a CLR write in the same cycle.
      if (state_q == CAPTURE) done_q <= 1'b1;
      else if (clr_req)       done_q <= 1'b0;

      if (timeout_hit)  err_q <= 1'b1;
      else if (clr_req) err_q <= 1'b0;

      if (ovr_hit)      ovr_q <= 1'b1;
      else if (clr_req) ovr_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start_req) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
          end
        end
        LAUNCH: begin
          cyc_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cyc_q <= cyc_inc;
          // The product becomes valid on the end_step edge. The result is
          // therefore taken one cycle later, in CAPTURE.
          if (func_end_step_i) begin
            state_q <= CAPTURE;
          end else if (timeout_hit) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end
        end
        CAPTURE: begin
          res_q   <= func_y_i;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign func_start_o = start_q;
  assign func_rst_o   = rst_i | abort_q;
  assign func_a_o     = a_q;
  assign func_b_o     = b_q;
  assign irq_o        = done_q & ie_q;

  // NOTE: the read mux assigns a default before the case so that every
  // path drives bus_rdata_o and no latch is inferred.
  always_comb begin
    bus_rdata_o = '0;
    unique case (widx)
      IDX_A:      bus_rdata_o = a_q;
      IDX_B:      bus_rdata_o = b_q;
      IDX_STATUS: bus_rdata_o = {27'd0, ovr_q, ie_q, err_q, done_q, busy};
      IDX_RES_LO: bus_rdata_o = res_q[31:0];
      IDX_RES_HI: bus_rdata_o = res_q[63:32];
      IDX_CYC:    bus_rdata_o = 32'(cyc_q);
      default:    bus_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_ui_func_mmio.sv
// ---------------------------------------------------------------------------
// tb_ui_func_mmio
//
// Directed bench for ui_func_mmio. A small behavioural ui_func stub
// computes a * isqrt(b). It raises end_step after RUN_LEN cycles and
// updates its result on the end_step edge. With stub_hold set, it never
// finishes, which lets the watchdog fire.
// ---------------------------------------------------------------------------
module tb_ui_func_mmio;

  localparam int         RUN_LEN  = 17;
  localparam logic [4:0] AD_A     = 5'h00;
  localparam logic [4:0] AD_B     = 5'h04;
  localparam logic [4:0] AD_CTRL  = 5'h08;
  localparam logic [4:0] AD_STAT  = 5'h0C;
  localparam logic [4:0] AD_RESLO = 5'h10;
  localparam logic [4:0] AD_RESHI = 5'h14;
  localparam logic [4:0] AD_CYC   = 5'h18;
  localparam logic [4:0] AD_NONE  = 5'h1C;

  logic        clk;
  logic        rst;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        func_rst;
  logic        func_start;
  logic [31:0] func_a;
  logic [31:0] func_b;
  logic [63:0] func_y;
  logic        func_busy;
  logic        func_end_step;
  logic        irq;

  int vectors = 0;
  int fails   = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  logic stub_hold = 1'b0;

  ui_func_mmio dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus_we_i        (bus_we),
    .bus_addr_i      (bus_addr),
    .bus_wdata_i     (bus_wdata),
    .bus_rdata_o     (bus_rdata),
    .func_rst_o      (func_rst),
    .func_start_o    (func_start),
    .func_a_o        (func_a),
    .func_b_o        (func_b),
    .func_y_i        (func_y),
    .func_busy_i     (func_busy),
    .func_end_step_i (func_end_step),
    .irq_o           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ui_func stub ----------------
  function automatic logic [31:0] isqrt(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t = r | (32'd1 << i);
      if (64'(t) * 64'(t) <= 64'(v)) r = t;
    end
    return r;
  endfunction

  int m_cnt;
  always @(posedge clk or posedge func_rst) begin
    if (func_rst) begin
      func_busy <= 1'b0;
      m_cnt     <= 0;
      func_y    <= '0;
    end else if (func_start) begin
      func_busy <= 1'b1;
      m_cnt     <= RUN_LEN;
      func_y    <= 64'hA5A5_A5A5_5A5A_5A5A;
    end else if (func_busy) begin
      if (m_cnt == 1 && !stub_hold) begin
        func_busy <= 1'b0;
        func_y    <= 64'(func_a) * 64'(isqrt(func_b));
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign func_end_step = func_busy && (m_cnt == 1) && !stub_hold;

  // Pulse monitors.
  always @(posedge clk) begin
    if (!rst && func_start) start_cnt++;
    if (!rst && func_rst)   abort_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_addr = addr;
    #1;
    data = bus_rdata;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  // Polls STATUS until any bit in mask is set, bounded.
  task automatic wait_status(input string tag, input logic [31:0] mask);
    logic [31:0] s;
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus_read(AD_STAT, s);
      if ((s & mask) != 0) begin
        hit = 1'b1;
        break;
      end
    end
    check(tag, 64'(hit), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic hit;
    rst       = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = AD_STAT;
    bus_wdata = '0;

    // Reset state.
    #3;
    check("rst_func_rst", 64'(func_rst), 64'd1);
    check("rst_start",    64'(func_start), 64'd0);
    check("rst_irq",      64'(irq), 64'd0);
    check("rst_status",   64'(bus_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_func_rst", 64'(func_rst), 64'd0);
    rd_check("rst_a",     AD_A, 32'd0);
    rd_check("rst_reslo", AD_RESLO, 32'd0);
    rd_check("rst_cyc",   AD_CYC, 32'd0);

    // Basic run: 3 * isqrt(16) = 12, RUN lasts RUN_LEN cycles.
    bus_write(AD_A, 32'd3);
    bus_write(AD_B, 32'd16);
    rd_check("a_readback_byteoff", 5'h01, 32'd3);
    rd_check("ctrl_reads0", AD_CTRL, 32'd0);
    rd_check("idx7_reads0", AD_NONE, 32'd0);
    bus_write(AD_CTRL, 32'h5);
    wait_status("basic_wait", 32'h2);
    rd_check("basic_status", AD_STAT, 32'h0A);
    rd_check("basic_reslo",  AD_RESLO, 32'd12);
    rd_check("basic_reshi",  AD_RESHI, 32'd0);
    rd_check("basic_cyc",    AD_CYC, 32'd17);
    check("basic_irq",       64'(irq), 64'd1);
    check("basic_starts",    64'(start_cnt), 64'd1);

    // Full-scale operands, launched with CLR+START+IE.
    bus_write(AD_A, 32'hFFFF_FFFF);
    bus_write(AD_B, 32'hFFFF_FFFF);
    bus_write(AD_CTRL, 32'h7);
    wait_status("full_wait", 32'h2);
    rd_check("full_status", AD_STAT, 32'h0A);
    rd_check("full_reshi",  AD_RESHI, 32'h0000_FFFE);
    rd_check("full_reslo",  AD_RESLO, 32'hFFFF_0001);

    // Overrun: B written during the second RUN cycle must be dropped.
    bus_write(AD_A, 32'd2);
    bus_write(AD_B, 32'd81);
    bus_write(AD_CTRL, 32'h7);
    repeat (2) @(posedge clk);
    bus_write(AD_B, 32'd100);
    rd_check("ovr_busy_status", AD_STAT, 32'h19);
    wait_status("ovr_wait", 32'h2);
    rd_check("ovr_status", AD_STAT, 32'h1A);
    rd_check("ovr_reslo",  AD_RESLO, 32'd18);
    rd_check("ovr_b_kept", AD_B, 32'd81);
    check("ovr_func_b",    64'(func_b), 64'd81);
    bus_write(AD_CTRL, 32'h2);
    rd_check("clr_status", AD_STAT, 32'h0);
    check("clr_irq",       64'(irq), 64'd0);

    // Flag collision: CLR lands in the CAPTURE cycle; done must survive.
    bus_write(AD_A, 32'd7);
    bus_write(AD_B, 32'd49);
    bus_write(AD_CTRL, 32'h3);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (func_end_step) begin
        hit = 1'b1;
        break;
      end
    end
    check("coll_endstep_seen", 64'(hit), 64'd1);
    bus_write(AD_CTRL, 32'h2);
    rd_check("coll_status", AD_STAT, 32'h02);
    rd_check("coll_reslo",  AD_RESLO, 32'd49);

    // Watchdog: the stub never finishes.
    stub_hold = 1'b1;
    bus_write(AD_CTRL, 32'h3);
    wait_status("wdog_wait", 32'h4);
    rd_check("wdog_status", AD_STAT, 32'h04);
    rd_check("wdog_cyc",    AD_CYC, 32'd200);
    rd_check("wdog_reslo",  AD_RESLO, 32'd49);
    rd_check("wdog_reshi",  AD_RESHI, 32'd0);
    check("wdog_abort_pulses", 64'(abort_cnt), 64'd1);
    stub_hold = 1'b0;

    // Mid-operation asynchronous reset.
    bus_write(AD_A, 32'd9);
    bus_write(AD_B, 32'd4);
    bus_write(AD_CTRL, 32'h7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    bus_addr = AD_STAT;
    #1;
    check("mrst_status",   64'(bus_rdata), 64'd0);
    check("mrst_func_rst", 64'(func_rst), 64'd1);
    check("mrst_start",    64'(func_start), 64'd0);
    check("mrst_irq",      64'(irq), 64'd0);
    check("mrst_ops",      64'({func_a, func_b}), 64'd0);
    bus_addr = AD_RESLO;
    #1;
    check("mrst_reslo",    64'(bus_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_write(AD_A, 32'd5);
    bus_write(AD_B, 32'd25);
    bus_write(AD_CTRL, 32'h1);
    wait_status("post_wait", 32'h2);
    rd_check("post_reslo",  AD_RESLO, 32'd25);
    rd_check("post_reshi",  AD_RESHI, 32'd0);
    rd_check("post_status", AD_STAT, 32'h02);
    check("total_starts",   64'(start_cnt), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
